timer_loader: RTL and testbench

- Consumer end of the keypad encoder interface; receives BCD digits and the 1 Hz tick, and drives the encoder's entry enable.
- Digit entry: each keypad strobe shifts one BCD digit into a 4-digit MM:SS register, right-to-left.
- Start/stop control runs a countdown clocked by the 1 Hz tick.
- Drives the display digits, the magnetron "running" signal, and a done pulse.

---
 rtl/timer_loader.sv | 148 ++++++++++++++
 tb/tb_timer_loader.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/timer_loader.sv
// rtl/timer_loader.sv - keypad-loaded MM:SS countdown timer with run/pause/done control
module timer_loader #(
  parameter int SEC_TENS_MAX = 5,
  parameter int MIN_TENS_MAX = 9
) (
  input  logic       clk,
  input  logic       clearn,
  input  logic [3:0] bcd_input,
  input  logic       loadn,
  input  logic       pgt_1hz,
  input  logic       startn,
  input  logic       stopn,
  output logic       enablen,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       zero,
  output logic       done
);

  localparam logic [3:0] ST_MAX = 4'(SEC_TENS_MAX);
  localparam logic [3:0] MT_MAX = 4'(MIN_TENS_MAX);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t     state;
  logic       loadn_q, pgt_q, stopn_q;
  logic       load_evt, tick_evt, stop_evt;
  logic [3:0] d_mt, d_mo, d_st, d_so;
  logic       dec_zero;

  assign load_evt = loadn_q & ~loadn;
  assign tick_evt = ~pgt_q & pgt_1hz;
  assign stop_evt = stopn_q & ~stopn;
  assign zero     = (min_tens == 4'd0) && (min_ones == 4'd0) &&
                    (sec_tens == 4'd0) && (sec_ones == 4'd0);

  // One-second decrement of MM:SS with cascaded digit borrows
  always_comb begin
    d_mt = min_tens;
    d_mo = min_ones;
    d_st = sec_tens;
    d_so = sec_ones;
    if (sec_ones != 4'd0) begin
      d_so = sec_ones - 4'd1;
    end else begin
      d_so = 4'd9;
      if (sec_tens != 4'd0) begin
        d_st = sec_tens - 4'd1;
      end else begin
        d_st = ST_MAX;
        if (min_ones != 4'd0) begin
          d_mo = min_ones - 4'd1;
        end else begin
          d_mo = 4'd9;
          d_mt = (min_tens != 4'd0) ? (min_tens - 4'd1) : MT_MAX;
        end
      end
    end
    dec_zero = (d_mt == 4'd0) && (d_mo == 4'd0) && (d_st == 4'd0) && (d_so == 4'd0);
  end

  // Control FSM, digit register and edge-detect history with registered outputs
  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) begin
      state    <= IDLE;
      min_tens <= 4'd0;
      min_ones <= 4'd0;
      sec_tens <= 4'd0;
      sec_ones <= 4'd0;
      enablen  <= 1'b0;
      running  <= 1'b0;
      done     <= 1'b0;
      loadn_q  <= 1'b1;
      pgt_q    <= 1'b0;
      stopn_q  <= 1'b1;
    end else begin
      loadn_q <= loadn;
      pgt_q   <= pgt_1hz;
      stopn_q <= stopn;
      done    <= 1'b0;
      case (state)
        IDLE: begin
          if (stop_evt) begin
            min_tens <= 4'd0;
            min_ones <= 4'd0;
            sec_tens <= 4'd0;
            sec_ones <= 4'd0;
          end else if (load_evt) begin
            // Out-of-range codes from the encoder are dropped
            if (bcd_input <= 4'd9) begin
              min_tens <= min_ones;
              min_ones <= sec_tens;
              sec_tens <= sec_ones;
              sec_ones <= bcd_input;
            end
          end else if (!startn && !zero) begin
            state   <= RUN;
            enablen <= 1'b1;
            running <= 1'b1;
          end
        end
        RUN: begin
          if (tick_evt) begin
            min_tens <= d_mt;
            min_ones <= d_mo;
            sec_tens <= d_st;
            sec_ones <= d_so;
          end
          // Reaching 00:00 takes precedence over a simultaneous stop
          if (tick_evt && dec_zero) begin
            state   <= DONE;
            running <= 1'b0;
            done    <= 1'b1;
          end else if (stop_evt) begin
            state   <= PAUSE;
            running <= 1'b0;
          end
        end
        PAUSE: begin
          if (stop_evt) begin
            state    <= IDLE;
            enablen  <= 1'b0;
            min_tens <= 4'd0;
            min_ones <= 4'd0;
            sec_tens <= 4'd0;
            sec_ones <= 4'd0;
          end else if (!startn) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        DONE: begin
          state   <= IDLE;
          enablen <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          enablen <= 1'b0;
          running <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_timer_loader.sv
// tb/tb_timer_loader.sv - directed self-checking bench for timer_loader
module tb_timer_loader;

  logic       clk = 1'b0;
  logic       clearn;
  logic [3:0] bcd_input;
  logic       loadn, pgt_1hz, startn, stopn;
  logic       enablen, running, zero, done;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic [15:0] digits;

  int vectors = 0;
  int miscompares = 0;

  timer_loader #(.SEC_TENS_MAX(5), .MIN_TENS_MAX(9)) dut (
    .clk(clk), .clearn(clearn), .bcd_input(bcd_input), .loadn(loadn),
    .pgt_1hz(pgt_1hz), .startn(startn), .stopn(stopn), .enablen(enablen),
    .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens),
    .sec_ones(sec_ones), .running(running), .zero(zero), .done(done)
  );

  always #5 clk = ~clk;

  assign digits = {min_tens, min_ones, sec_tens, sec_ones};

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load_digit(input logic [3:0] d);
    bcd_input = d;
    loadn = 1'b0;
    cyc();
    loadn = 1'b1;
    cyc();
  endtask

  task automatic tick();
    pgt_1hz = 1'b1;
    cyc();
    pgt_1hz = 1'b0;
    cyc();
  endtask

  task automatic stop_pulse();
    stopn = 1'b0;
    cyc();
    stopn = 1'b1;
    cyc();
  endtask

  task automatic start_run();
    startn = 1'b0;
    cyc();
    startn = 1'b1;
  endtask

  initial begin
    clearn = 1'b0; bcd_input = 4'd0; loadn = 1'b1;
    pgt_1hz = 1'b0; startn = 1'b1; stopn = 1'b1;
    cyc(); cyc();
    chk("rst_digits", digits, 16'h0000);
    chk("rst_enablen", 16'(enablen), 16'd0);
    chk("rst_running", 16'(running), 16'd0);
    chk("rst_zero", 16'(zero), 16'd1);
    chk("rst_done", 16'(done), 16'd0);
    clearn = 1'b1;
    cyc();

    // Right-to-left digit entry
    load_digit(4'd1); chk("load1", digits, 16'h0001);
    load_digit(4'd2); chk("load2", digits, 16'h0012);
    load_digit(4'd3); chk("load3", digits, 16'h0123);
    load_digit(4'd0); chk("load0", digits, 16'h1230);
    chk("nonzero", 16'(zero), 16'd0);
    load_digit(4'd12); chk("bad_bcd", digits, 16'h1230);
    bcd_input = 4'd4; loadn = 1'b0;
    repeat (10) cyc();
    loadn = 1'b1; cyc();
    chk("held_loadn", digits, 16'h2304);
    stop_pulse(); chk("idle_stop_clear", digits, 16'h0000);

    // 01:00 countdown to completion
    load_digit(4'd1); load_digit(4'd0); load_digit(4'd0);
    chk("load_0100", digits, 16'h0100);
    start_run();
    chk("run_running", 16'(running), 16'd1);
    chk("run_enablen", 16'(enablen), 16'd1);
    tick(); chk("tick_0059", digits, 16'h0059);
    for (int s = 58; s >= 1; s--) begin
      tick();
      chk("countdown", digits, 16'({4'd0, 4'd0, 4'(s / 10), 4'(s % 10)}));
    end
    pgt_1hz = 1'b1; cyc();
    chk("final_digits", digits, 16'h0000);
    chk("done_hi", 16'(done), 16'd1);
    chk("done_running", 16'(running), 16'd0);
    chk("done_enablen", 16'(enablen), 16'd1);
    pgt_1hz = 1'b0; cyc();
    chk("done_lo", 16'(done), 16'd0);
    chk("idle_enablen", 16'(enablen), 16'd0);

    // Unvalidated entry and minute borrows
    load_digit(4'd9); load_digit(4'd9);
    start_run(); tick(); chk("tick_0098", digits, 16'h0098);
    stop_pulse(); stop_pulse(); chk("clear_0098", digits, 16'h0000);
    load_digit(4'd1); load_digit(4'd0); load_digit(4'd0); load_digit(4'd0);
    start_run(); tick(); chk("tick_0959", digits, 16'h0959);
    stop_pulse(); stop_pulse(); chk("clear_0959", digits, 16'h0000);

    // Pause, hold, resume, clear
    load_digit(4'd0); load_digit(4'd5);
    start_run();
    stop_pulse();
    chk("pause_running", 16'(running), 16'd0);
    chk("pause_enablen", 16'(enablen), 16'd1);
    tick(); tick(); tick();
    chk("pause_hold", digits, 16'h0005);
    start_run();
    chk("resume_running", 16'(running), 16'd1);
    tick(); chk("resume_tick", digits, 16'h0004);
    stop_pulse(); stop_pulse();
    chk("stop2_digits", digits, 16'h0000);
    chk("stop2_enablen", 16'(enablen), 16'd0);
    chk("stop2_running", 16'(running), 16'd0);

    // Start refused at 00:00
    startn = 1'b0; cyc(); cyc();
    chk("zero_start_running", 16'(running), 16'd0);
    chk("zero_start_enablen", 16'(enablen), 16'd0);
    startn = 1'b1; cyc();

    // Tick and stop together on the last second
    load_digit(4'd0); load_digit(4'd1);
    start_run();
    pgt_1hz = 1'b1; stopn = 1'b0; cyc();
    chk("tickstop_digits", digits, 16'h0000);
    chk("tickstop_done", 16'(done), 16'd1);
    chk("tickstop_running", 16'(running), 16'd0);
    pgt_1hz = 1'b0; stopn = 1'b1; cyc();
    chk("tickstop_idle_en", 16'(enablen), 16'd0);
    chk("tickstop_done_lo", 16'(done), 16'd0);

    // Asynchronous reset mid-run
    load_digit(4'd3); load_digit(4'd0);
    chk("load_0030", digits, 16'h0030);
    start_run();
    cyc();
    chk("pre_rst_running", 16'(running), 16'd1);
    #2 clearn = 1'b0;
    #1;
    chk("async_rst_digits", digits, 16'h0000);
    chk("async_rst_running", 16'(running), 16'd0);
    cyc();
    chk("async_rst_done", 16'(done), 16'd0);
    clearn = 1'b1;
    cyc();
    chk("post_rst_done", 16'(done), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
